// File: rtl/hc161_pkg.sv
// rtl/hc161_pkg.sv - shared constants for the HC-series counter models
package hc161_pkg;

    // Counter width shared by hc161, hc163 and hc191
    localparam int HC_CNT_W = 4;

    // State at which terminal count is decoded
    localparam logic [HC_CNT_W-1:0] HC_TC_VALUE = 4'hF;

endpackage

// File: rtl/hc161_next.sv
// rtl/hc161_next.sv - next-state and terminal-count decode for the hc161 counter
module hc161_next
    import hc161_pkg::*;
(
    input  logic [HC_CNT_W-1:0] q,
    input  logic [HC_CNT_W-1:0] d,
    input  logic                pe_n,
    input  logic                cep,
    input  logic                cet,
    output logic [HC_CNT_W-1:0] qnext,
    output logic                tc_next
);

    // Load beats count, count beats hold; an unknown control yields an unknown state
    always_comb begin
        qnext = q;
        case (pe_n)
            1'b0: qnext = d;
            1'b1: begin
                case (cep & cet)
                    1'b1:    qnext = q + HC_CNT_W'(1);
                    1'b0:    qnext = q;
                    default: qnext = 'x;
                endcase
            end
            default: qnext = 'x;
        endcase
    end

    // Terminal count as it will look after the coming edge
    always_comb begin
        tc_next = cet & (qnext == HC_TC_VALUE);
    end

endmodule

// File: rtl/hc161.sv
// rtl/hc161.sv - 74HC161 4-bit presettable counter, pin level; HC161_TC_REG_EN registers TC
module hc161
    import hc161_pkg::*;
(
    input  logic p1,   // MR_n
    input  logic p2,   // CP
    input  logic p3,   // D0
    input  logic p4,   // D1
    input  logic p5,   // D2
    input  logic p6,   // D3
    input  logic p7,   // CEP
    input  logic p9,   // PE_n
    input  logic p10,  // CET
    output logic p11,  // Q3
    output logic p12,  // Q2
    output logic p13,  // Q1
    output logic p14,  // Q0
    output logic p15   // TC
);

    logic [HC_CNT_W-1:0] q;
    logic [HC_CNT_W-1:0] qnext;
    logic                tc_next;
    logic                tc;

    hc161_next u_next (
        .q       (q),
        .d       ({p6, p5, p4, p3}),
        .pe_n    (p9),
        .cep     (p7),
        .cet     (p10),
        .qnext   (qnext),
        .tc_next (tc_next)
    );

    // Counter state, cleared asynchronously by MR_n
    always_ff @(posedge p2 or negedge p1) begin
        if (!p1) begin
            q <= '0;
        end else begin
            q <= qnext;
        end
    end

`ifdef HC161_TC_REG_EN
    logic tc_q;

    // Registered TC tracks Q exactly; CET changes show up one edge late
    always_ff @(posedge p2 or negedge p1) begin
        if (!p1) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_next;
        end
    end

    assign tc = tc_q;
`else
    logic unused_tc_next;
    assign unused_tc_next = tc_next;

    // Combinational TC so cascaded stages ripple within one cycle
    assign tc = p10 & (q == HC_TC_VALUE);
`endif

    assign p14 = q[0];
    assign p13 = q[1];
    assign p12 = q[2];
    assign p11 = q[3];
    assign p15 = tc;

endmodule

// File: tb/tb_hc161.sv
// tb/tb_hc161.sv - self-checking bench for hc161 with a two-stage cascade
module tb_hc161;

    logic       p1;
    logic       p2;
    logic [3:0] d;
    logic       cep;
    logic       cet;
    logic       pe_n_drv;
    logic       mod10;
    wire        p9;
    wire        p11, p12, p13, p14, p15;
    wire        s2_q3, s2_q2, s2_q1, s2_q0, s2_tc;

    wire [3:0] q  = {p11, p12, p13, p14};
    wire [3:0] q2 = {s2_q3, s2_q2, s2_q1, s2_q0};

    // Mod-10 wiring: NAND of Q3 and Q0 decodes state 9 so the synchronous load wraps 9 -> 0
    assign p9 = mod10 ? ~(q[3] & q[0]) : pe_n_drv;

    hc161 dut (
        .p1(p1), .p2(p2), .p3(d[0]), .p4(d[1]), .p5(d[2]), .p6(d[3]),
        .p7(cep), .p9(p9), .p10(cet),
        .p11(p11), .p12(p12), .p13(p13), .p14(p14), .p15(p15)
    );

    hc161 dut2 (
        .p1(p1), .p2(p2), .p3(1'b0), .p4(1'b0), .p5(1'b0), .p6(1'b0),
        .p7(1'b1), .p9(1'b1), .p10(p15),
        .p11(s2_q3), .p12(s2_q2), .p13(s2_q1), .p14(s2_q0), .p15(s2_tc)
    );

    initial p2 = 1'b0;
    always #5 p2 = ~p2;

    logic [4:0] exp_q[$];
    logic [4:0] exp2_q[$];
    int total = 0;
    int bad   = 0;
    int tc2_pulses;

    task automatic expect1(input logic tc_e, input logic [3:0] q_e);
        exp_q.push_back({tc_e, q_e});
    endtask

    task automatic check(input string tag);
        logic [4:0] e;
        logic [4:0] o;
        e = exp_q.pop_front();
        o = {p15, q};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed tc,q=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic check2(input string tag);
        logic [4:0] e;
        logic [4:0] o;
        e = exp2_q.pop_front();
        o = {s2_tc, q2};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed tc2,q2=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge p2);
        #1;
    endtask

    initial begin
        p1 = 1'b0; d = 4'h0; cep = 1'b0; cet = 1'b0; pe_n_drv = 1'b1; mod10 = 1'b0;

        // reset state
        tick();
        expect1(1'b0, 4'h0); check("reset");
        p1 = 1'b1;

        // count to 0110, then reset mid-cycle
        cep = 1'b1; cet = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        expect1(1'b0, 4'h6); check("count_to_6");
        #3 p1 = 1'b0;
        #1 expect1(1'b0, 4'h0); check("mr_async_clear");
        @(posedge p2);
        #1 p1 = 1'b1;
        expect1(1'b0, 4'h0); check("mr_release_edge_ignored");
        tick();
        expect1(1'b0, 4'h1); check("first_edge_after_release");

        // load priority over counting
        pe_n_drv = 1'b0; cep = 1'b0; cet = 1'b0; d = 4'hB;
        tick();
        expect1(1'b0, 4'hB); check("load_no_enable");
        cep = 1'b1; cet = 1'b1;
        tick();
        expect1(1'b0, 4'hB); check("load_over_count");

        // wrap and TC
        d = 4'hE;
        tick();
        expect1(1'b0, 4'hE); check("load_1110");
        pe_n_drv = 1'b1;
        tick();
        expect1(1'b1, 4'hF); check("count_to_1111_tc");
        tick();
        expect1(1'b0, 4'h0); check("wrap_to_0000");

        // load 1010 then 1111, then reload 1111 with enables high
        pe_n_drv = 1'b0; d = 4'hA;
        tick();
        expect1(1'b0, 4'hA); check("load_1010");
        d = 4'hF;
        tick();
        expect1(1'b1, 4'hF); check("load_1010_to_1111");
        tick();
        expect1(1'b1, 4'hF); check("load_equal_at_1111");

        // hold at 1111 and drop CET without a clock edge
        pe_n_drv = 1'b1; cep = 1'b0;
        tick();
        expect1(1'b1, 4'hF); check("hold_1111");
        #2 cet = 1'b0;
        #1 expect1(1'b0, 4'hF); check("tc_follows_cet");
        #1 cet = 1'b1;
        #1 expect1(1'b1, 4'hF); check("tc_rises_with_cet");
        p1 = 1'b0;
        #1 expect1(1'b0, 4'h0); check("mr_clears_tc");
        p1 = 1'b1;

        // enables one at a time must not count
        pe_n_drv = 1'b0; d = 4'h3;
        tick();
        expect1(1'b0, 4'h3); check("load_0011");
        pe_n_drv = 1'b1; cep = 1'b1; cet = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect1(1'b0, 4'h3); check("cep_only_hold");
        end
        cep = 1'b0; cet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect1(1'b0, 4'h3); check("cet_only_hold");
        end

        // mod-10 via NAND feedback into PE_n
        pe_n_drv = 1'b0; d = 4'h0;
        tick();
        expect1(1'b0, 4'h0); check("mod10_start");
        mod10 = 1'b1; cep = 1'b1; cet = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            expect1(1'b0, 4'(i % 10)); check("mod10_step");
        end
        mod10 = 1'b0; pe_n_drv = 1'b1;

        // two-stage cascade over 256 edges from zero
        #2 p1 = 1'b0;
        #1 p1 = 1'b1;
        tc2_pulses = 0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            expect1(((k % 256) % 16) == 15, 4'((k % 256) % 16));
            exp2_q.push_back({(k % 256) == 255, 4'((k % 256) / 16)});
            check("cascade_stage1");
            check2("cascade_stage2");
            if (s2_tc === 1'b1) tc2_pulses++;
        end
        total++;
        assert (tc2_pulses == 1) else begin
            bad++;
            $error("FAIL cascade_tc2_pulses observed=%0d expected=1", tc2_pulses);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
